frame_ones_counter: RTL and testbench
=====================================

# frame_ones_counter

Sequential ones-counting stage that consumes a stream of 3-bit words and reports the total number of set bits per frame. It sits directly downstream of the 3-input ones-count logic, in the sense that each accepted word is reduced by a combinational 3-bit popcount and the 2-bit results are accumulated over a frame. A frame ends after FRAME_WORDS words or on an early in_last. The block emits one result per frame over a valid/ready handshake.

## Interface
- FRAME_WORDS, 8: maximum words per frame; must be ≥ 1.
- CNT_W, $clog2(3*FRAME_WORDS+1): width of out_count; derived, not overridden.
- WRD_W, $clog2(FRAME_WORDS+1): width of out_words; derived, not overridden.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  3  word whose set bits are counted.
- in_last  in  1  qualified by in_valid; marks the final word of a short frame.
- out_valid  out  1  frame result is available.
- out_ready  in  1  downstream accepts the result.
- out_count  out  CNT_W  total set bits in the frame.
- out_words  out  WRD_W  number of words in the frame, 1..FRAME_WORDS.
- out_major  out  1  1 when 2*out_count > 3*out_words, i.e. a strict majority of the frame's bits are set.

## Operation
- The block has two states, ACCUM and HOLD. Reset puts it in ACCUM with the accumulator and word counter at 0.
- Reset values:
  - out_valid=0, out_count=0, out_words=0, out_major=0.
  - in_ready=0 while rst=1.
- ACCUM:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready.
  - On accept: acc += popcount(in_data) (0..3) and wcnt += 1.
  - Cycles with in_valid=0 leave all state unchanged. in_data and in_last are don't-care in those cycles.
- End of frame: an accept with in_last=1 or with wcnt==FRAME_WORDS-1. On that edge:
  - out_count ← acc + popcount(in_data).
  - out_words ← wcnt + 1.
  - out_major is computed from those two values.
  - out_valid ← 1 and state → HOLD.
  - acc and wcnt clear.
- in_last on the FRAME_WORDS-th word is redundant and harmless.
- HOLD:
  - in_ready=0.
  - out_count, out_words and out_major are held stable.
  - out_valid stays 1 until out_ready=1.
  - On that handshake edge: out_valid ← 0 and state → ACCUM.
- No overlap: the first word of the next frame is accepted at the earliest in the cycle after the output handshake.
- Arithmetic is unsigned. The accumulator is CNT_W wide and cannot overflow, since the maximum is 3*FRAME_WORDS.
- Reset mid-frame or in HOLD discards the partial frame or pending result. No output is produced for it.
- out_ready while out_valid=0 is ignored.

## Timing
- in_ready is combinational from state and rst: in_ready = (state==ACCUM) && !rst. It has no combinational path from in_valid or out_ready.
- Latency: out_valid rises on the clock edge that accepts the last word, so it is visible in the next cycle.
- Throughput: the best case is FRAME_WORDS+1 cycles per full frame with out_ready held at 1.
- All outputs are registered except in_ready.
- Simultaneous events:
  - rst wins over everything.
  - In HOLD, in_valid is ignored; no word is lost because in_ready=0.

## Structure
- Shared package frame_ones_pkg holds:
  - the state enum (ACCUM, HOLD);
  - a function for popcount of 3 bits;
  - a function for the CNT_W/WRD_W width formulas.
- One sub-module is natural: ones_count3, a combinational 3-in/2-out popcount (out = {carry, sum}) instantiated on in_data.
- The accumulator, word counter, FSM and output registers live in the top module.

## Test plan
- FRAME_WORDS=4, words 111, 101, 000, 011 with in_valid always 1 and out_ready=1:
  - out_count=7, out_words=4, out_major=1 (14>12);
  - out_valid high for exactly one cycle, one cycle after the 4th accept.
- Early end: words 110, then 001 with in_last=1:
  - out_count=3, out_words=2, out_major=0 (6>6 is false);
  - next frame starts counting from 0.
- Backpressure: complete a frame, then hold out_ready=0 for 5 cycles with in_valid=1 and in_data=111:
  - in_ready=0 throughout;
  - out_count, out_words and out_major are constant;
  - after out_ready=1, the next frame's first accept is the following cycle and it counts from 0.
- Bubbles and maximum: all words 111 with in_valid toggling 1,0,1,0,…:
  - out_count=12 (3*FRAME_WORDS), out_words=4, no overflow;
  - idle cycles change nothing.
- Reset mid-frame: accept 111 and 111, assert rst for 1 cycle, then send four words of 001:
  - no output for the aborted frame;
  - result is out_count=4, out_words=4, out_major=0.
- Reset in HOLD with out_valid=1: out_valid=0 in the cycle after rst, and in_ready=1 once rst deasserts.

Source files
------------

// File: rtl/frame_ones_pkg.sv
// Shared types and helpers for the per-frame ones-counting stage.
// Holds the FSM state encoding, a 3-bit popcount and the counter-width formula.
package frame_ones_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic logic [1:0] popcount3(input logic [2:0] bits);
        return {1'b0, bits[0]} + {1'b0, bits[1]} + {1'b0, bits[2]};
    endfunction

    // Number of bits needed to represent every value in 0..max_val.
    function automatic int width_for(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ones_count3.sv
// Combinational 3-input ones counter: a full adder whose {carry, sum}
// is the number of set input bits.
module ones_count3 (
    input  logic [2:0] bits,
    output logic [1:0] count
);

    assign count[0] = ^bits;
    assign count[1] = (bits[0] & bits[1]) | (bits[0] & bits[2]) | (bits[1] & bits[2]);

endmodule

// File: rtl/frame_ones_counter.sv
// Accumulates the popcount of 3-bit words over a frame of up to FRAME_WORDS
// words and hands one registered result per frame downstream.
module frame_ones_counter
    import frame_ones_pkg::*;
#(
    parameter  int FRAME_WORDS = 8,
    localparam int CNT_W       = width_for(3 * FRAME_WORDS),
    localparam int WRD_W       = width_for(FRAME_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [WRD_W-1:0] out_words,
    output logic             out_major
);

    localparam int MAJ_W = CNT_W + 1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   acc_reg, acc_next;
    logic [WRD_W-1:0]   wcnt_reg, wcnt_next;
    logic               out_valid_reg, out_valid_next;
    logic [CNT_W-1:0]   out_count_reg, out_count_next;
    logic [WRD_W-1:0]   out_words_reg, out_words_next;
    logic               out_major_reg, out_major_next;

    logic [1:0]         word_ones;
    logic [CNT_W-1:0]   acc_sum;
    logic [WRD_W-1:0]   wcnt_inc;
    logic               frame_end;
    logic               accept;
    logic               major_calc;

    ones_count3 u_ones_count3 (
        .bits  (in_data),
        .count (word_ones)
    );

    assign in_ready   = (state_reg == ACCUM) && !rst;
    assign accept     = in_valid && (state_reg == ACCUM);
    assign acc_sum    = acc_reg + CNT_W'(word_ones);
    assign wcnt_inc   = wcnt_reg + WRD_W'(1);
    assign frame_end  = in_last || (wcnt_reg == WRD_W'(FRAME_WORDS - 1));
    // Strict majority: set bits exceed half of the 3*words bits in the frame.
    assign major_calc = (MAJ_W'(acc_sum) << 1) > (MAJ_W'(wcnt_inc) * MAJ_W'(3));

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        wcnt_next      = wcnt_reg;
        out_valid_next = out_valid_reg;
        out_count_next = out_count_reg;
        out_words_next = out_words_reg;
        out_major_next = out_major_reg;
        case (state_reg)
            ACCUM: begin
                if (accept) begin
                    if (frame_end) begin
                        out_count_next = acc_sum;
                        out_words_next = wcnt_inc;
                        out_major_next = major_calc;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        wcnt_next      = '0;
                        state_next     = HOLD;
                    end else begin
                        acc_next  = acc_sum;
                        wcnt_next = wcnt_inc;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            wcnt_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            out_words_reg <= '0;
            out_major_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            wcnt_reg      <= wcnt_next;
            out_valid_reg <= out_valid_next;
            out_count_reg <= out_count_next;
            out_words_reg <= out_words_next;
            out_major_reg <= out_major_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_count = out_count_reg;
    assign out_words = out_words_reg;
    assign out_major = out_major_reg;

endmodule

// File: tb/tb_frame_ones_counter.sv
// Directed bench for frame_ones_counter with a result scoreboard filled on
// accepted stimulus and drained whenever a frame result is handed off.
module tb_frame_ones_counter;

    localparam int FW    = 4;
    localparam int CNT_W = $clog2(3 * FW + 1);
    localparam int WRD_W = $clog2(FW + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic [WRD_W-1:0] out_words;
    logic             out_major;

    typedef struct {
        int cnt;
        int words;
        int major;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t hold_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   m_acc    = 0;
    int   m_words  = 0;
    int   last_acc_cyc = 0;
    int   hs_cyc   = 0;

    frame_ones_counter #(.FRAME_WORDS(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_words (out_words),
        .out_major (out_major)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ones(input logic [2:0] d);
        return int'(d[0]) + int'(d[1]) + int'(d[2]);
    endfunction

    // Drive one word, wait (bounded) for acceptance, and update the model.
    task automatic send(input logic [2:0] d, input logic last);
        int waited;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            last_acc_cyc = cyc;
            m_acc   += ones(d);
            m_words += 1;
            $display("word data=%b last=%0d acc=%0d words=%0d", d, last, m_acc, m_words);
            if (last || m_words == FW) begin
                e.cnt   = m_acc;
                e.words = m_words;
                e.major = (2 * m_acc > 3 * m_words) ? 1 : 0;
                q.push_back(e);
                m_acc   = 0;
                m_words = 0;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = q.pop_front();
                $display("frame count=%0d words=%0d major=%0d exp=%0d/%0d/%0d",
                         out_count, out_words, out_major, mon_e.cnt, mon_e.words, mon_e.major);
                check("out_count", 32'(out_count), mon_e.cnt);
                check("out_words", 32'(out_words), mon_e.words);
                check("out_major", 32'(out_major), mon_e.major);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 3'b000;
        in_last   = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        idle(1);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_out_words", 32'(out_words), 0);
        check("rst_out_major", 32'(out_major), 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 1);
        idle(1);

        // Full frame, continuous valid: 7 ones, majority.
        send(3'b111, 1'b0);
        send(3'b101, 1'b0);
        send(3'b000, 1'b0);
        send(3'b011, 1'b0);
        @(negedge clk);
        check("full_valid_rises", 32'(out_valid), 1);
        @(negedge clk);
        check("full_valid_one_cycle", 32'(out_valid), 0);
        check("full_ready_back", 32'(in_ready), 1);
        idle(1);

        // Early end: 3 ones over 2 words, not a majority.
        send(3'b110, 1'b0);
        send(3'b001, 1'b1);
        idle(2);

        // Backpressure: result held while downstream stalls.
        out_ready = 1'b0;
        send(3'b100, 1'b0);
        send(3'b111, 1'b0);
        send(3'b010, 1'b0);
        send(3'b110, 1'b0);
        hold_e = q[q.size() - 1];
        in_valid = 1'b1;
        in_data  = 3'b111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_count", 32'(out_count), hold_e.cnt);
            check("stall_words", 32'(out_words), hold_e.words);
            check("stall_major", 32'(out_major), hold_e.major);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        send(3'b111, 1'b0);
        check("first_accept_after_hs", last_acc_cyc, hs_cyc + 1);
        send(3'b001, 1'b1);
        idle(2);

        // Bubbles with all-ones words: maximum count, idle cycles inert.
        for (int i = 0; i < FW; i++) begin
            send(3'b111, 1'b0);
            idle(1);
        end
        idle(2);

        // Reset mid-frame discards the partial frame.
        send(3'b111, 1'b0);
        send(3'b111, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_acc   = 0;
        m_words = 0;
        for (int i = 0; i < FW; i++) send(3'b001, 1'b0);
        idle(2);

        // Reset while a result is pending.
        out_ready = 1'b0;
        send(3'b111, 1'b0);
        send(3'b111, 1'b1);
        @(negedge clk);
        check("hold_valid", 32'(out_valid), 1);
        hold_e = q.pop_back();
        check("hold_count", 32'(out_count), hold_e.cnt);
        check("hold_major", 32'(out_major), hold_e.major);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("holdrst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("holdrst_out_valid", 32'(out_valid), 0);
        check("holdrst_in_ready_back", 32'(in_ready), 1);
        out_ready = 1'b1;
        idle(3);

        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
